// File: rtl/aes_iter_core.sv
// Iterative AES encryption core: one round per clock on a single 128-bit state register.
// Round keys are fetched from an external store addressed by rk_idx within the same cycle.
module aes_iter_core #(
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic [3:0]   rk_idx,
  input  logic [0:127] rk_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data
);

  localparam int         Nr = Nk + 6;
  localparam logic [3:0] NR = 4'(Nr);

  if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_bad_nk
    $error("aes_iter_core: Nk must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e       fsm;
  logic [3:0]   rnd;
  logic [0:127] st;
  logic [0:127] sr_st;
  logic [0:127] mid_st;
  logic [0:127] fin_st;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box as the field inverse (b^254 = b^2 * b^4 * ... * b^128) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = b;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [0:127] sub_shift(input logic [0:127] s);
    logic [0:127] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[8*(4*c+row) +: 8] = sbox(s[8*(4*((c+row)%4)+row) +: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      r[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  assign sr_st    = sub_shift(st);
  assign mid_st   = mix_columns(sr_st) ^ rk_in;
  assign fin_st   = sr_st ^ rk_in;
  assign out_data = st;

  // rk_idx tracks the key needed next: 0 while idle, rnd while busy, Nr once done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      rnd       <= '0;
      st        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rk_idx    <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            st       <= in_data ^ rk_in;
            rnd      <= 4'd1;
            rk_idx   <= 4'd1;
            in_ready <= 1'b0;
            fsm      <= BUSY;
          end
        end
        BUSY: begin
          if (rnd == NR) begin
            st        <= fin_st;
            rk_idx    <= NR;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            st     <= mid_st;
            rnd    <= rnd + 4'd1;
            rk_idx <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            rk_idx    <= '0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: Nk = 4/6/8 instances checked against a byte-level AES model
// (S-box derived by search over the field) and the FIPS-197 known-answer vectors.
module tb_aes_iter_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [0:127] in_data   [3];
  logic [3:0]   rk_idx    [3];
  logic [0:127] rk_in     [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [0:127] out_data  [3];

  logic [0:127] rk_store [3][16];
  logic [7:0]   sbox_tab [256];
  int           nk_tab   [3] = '{4, 6, 8};
  int           checks = 0;
  int           errors = 0;
  int           rk_trace [$];

  localparam logic [0:255] SEQ_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_iter_core #(.Nk(4 + 2*g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .rk_idx    (rk_idx[g]),
      .rk_in     (rk_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );
    assign rk_in[g] = rk_store[g][rk_idx[g]];
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, c, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic load_key(input int u, input logic [0:255] key);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk, nr;
    nk = nk_tab[u];
    nr = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < 64; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_store[u][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [0:127] aes_model(input int u, input logic [0:127] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [0:127] res;
    int nr;
    nr = nk_tab[u] + 6;
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rk_store[u][0][8*i +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row+4*c] = s[row+4*((c+row)%4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) a[row] = t[row+4*c];
          for (int row = 0; row < 4; row++)
            t[row+4*c] = gmul(8'h02, a[row]) ^ gmul(8'h03, a[(row+1)%4]) ^ a[(row+2)%4] ^ a[(row+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ rk_store[u][r][8*i +: 8];
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
    return res;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // lat counts edges after the accepting edge until out_valid; -1 if never accepted.
  task automatic run_block(input int u, input logic [0:127] pt, output int lat);
    int waited;
    waited = 0;
    rk_trace.delete();
    while (!in_ready[u] && waited < 40) begin @(posedge clk); #1; waited++; end
    if (!in_ready[u]) begin lat = -1; return; end
    in_data[u]  = pt;
    in_valid[u] = 1'b1;
    rk_trace.push_back(int'(rk_idx[u]));
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    in_data[u]  = rand128();
    lat = 0;
    while (!out_valid[u] && lat < 40) begin
      rk_trace.push_back(int'(rk_idx[u]));
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      in_valid[u] = 1'b1; in_data[u] = rand128(); out_ready[u] = 1'b0;
    end
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) begin
      checks += 4;
      if (in_ready[u] !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready u=%0d got %b want 1", u, in_ready[u]); end
      if (out_valid[u] !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid u=%0d got %b want 0", u, out_valid[u]); end
      if (rk_idx[u] !== 4'd0) begin errors++; $display("[TB] FAIL reset_rk_idx u=%0d got %0d want 0", u, rk_idx[u]); end
      if (out_data[u] !== 128'h0) begin errors++; $display("[TB] FAIL reset_out_data u=%0d got %h want 0", u, out_data[u]); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int u = 0; u < 3; u++) in_valid[u] = 1'b0;
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (in_ready[u] !== 1'b1 || rk_idx[u] !== 4'd0) begin
        errors++; $display("[TB] FAIL reset_no_accept u=%0d got in_ready=%b rk_idx=%0d want 1/0", u, in_ready[u], rk_idx[u]);
      end
    end
  endtask

  task automatic test_known_vectors();
    logic [0:127] kat [3];
    logic [0:127] pt;
    int lat;
    pt  = 128'h00112233445566778899aabbccddeeff;
    kat = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
            128'hdda97ca4864cdfe06eaf70a0ec0d7191,
            128'h8ea2b7ca516745bfeafc49904b496089};
    for (int u = 0; u < 3; u++) begin
      load_key(u, SEQ_KEY);
      out_ready[u] = 1'b1;
      run_block(u, pt, lat);
      checks += 3;
      if (lat != nk_tab[u] + 6) begin errors++; $display("[TB] FAIL kat_latency u=%0d got %0d want %0d", u, lat, nk_tab[u] + 6); end
      if (out_data[u] !== kat[u]) begin errors++; $display("[TB] FAIL kat_data u=%0d got %h want %h", u, out_data[u], kat[u]); end
      if (out_data[u] !== aes_model(u, pt)) begin errors++; $display("[TB] FAIL kat_model u=%0d got %h want %h", u, out_data[u], aes_model(u, pt)); end
      @(posedge clk); #1;
      checks++;
      if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0) begin
        errors++; $display("[TB] FAIL kat_handoff u=%0d got in_ready=%b out_valid=%b want 1/0", u, in_ready[u], out_valid[u]);
      end
    end
  endtask

  task automatic test_rk_trace();
    logic [0:127] pt;
    int lat, nr;
    for (int u = 0; u < 3; u++) begin
      nr = nk_tab[u] + 6;
      pt = rand128();
      out_ready[u] = 1'b1;
      run_block(u, pt, lat);
      checks += 3;
      if (rk_trace.size() != nr + 1) begin errors++; $display("[TB] FAIL rk_trace_len u=%0d got %0d want %0d", u, rk_trace.size(), nr + 1); end
      else begin
        for (int i = 0; i <= nr; i++) begin
          checks++;
          if (rk_trace[i] != i) begin errors++; $display("[TB] FAIL rk_trace u=%0d step %0d got %0d want %0d", u, i, rk_trace[i], i); end
        end
      end
      if (rk_idx[u] !== 4'(nr)) begin errors++; $display("[TB] FAIL rk_done u=%0d got %0d want %0d", u, rk_idx[u], nr); end
      if (out_data[u] !== aes_model(u, pt)) begin errors++; $display("[TB] FAIL rk_trace_data u=%0d got %h want %h", u, out_data[u], aes_model(u, pt)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall(input int u);
    logic [0:127] pt, exp;
    int lat, nr;
    nr = nk_tab[u] + 6;
    pt = rand128();
    exp = aes_model(u, pt);
    out_ready[u] = 1'b0;
    run_block(u, pt, lat);
    checks++;
    if (lat != nr) begin errors++; $display("[TB] FAIL stall_latency u=%0d got %0d want %0d", u, lat, nr); end
    for (int k = 0; k < 5; k++) begin
      in_valid[u] = 1'b1;
      in_data[u]  = rand128();
      checks += 4;
      if (out_valid[u] !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid u=%0d cyc %0d got %b want 1", u, k, out_valid[u]); end
      if (out_data[u] !== exp) begin errors++; $display("[TB] FAIL stall_data u=%0d cyc %0d got %h want %h", u, k, out_data[u], exp); end
      if (in_ready[u] !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready u=%0d cyc %0d got %b want 0", u, k, in_ready[u]); end
      if (rk_idx[u] !== 4'(nr)) begin errors++; $display("[TB] FAIL stall_rk_idx u=%0d cyc %0d got %0d want %0d", u, k, rk_idx[u], nr); end
      @(posedge clk); #1;
    end
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid[u] !== 1'b0 || in_ready[u] !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_release u=%0d got out_valid=%b in_ready=%b want 0/1", u, out_valid[u], in_ready[u]);
    end
  endtask

  task automatic test_reset_midflight();
    logic [0:127] pt;
    int waited, lat, u;
    bit seen;
    u = 1;
    out_ready[u] = 1'b1;
    in_data[u]   = rand128();
    in_valid[u]  = 1'b1;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    waited = 0;
    while (rk_idx[u] !== 4'd5 && waited < 40) begin @(posedge clk); #1; waited++; end
    checks++;
    if (rk_idx[u] !== 4'd5) begin errors++; $display("[TB] FAIL abort_reach_rnd5 got %0d want 5", rk_idx[u]); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks += 4;
    if (in_ready[u] !== 1'b1) begin errors++; $display("[TB] FAIL abort_in_ready got %b want 1", in_ready[u]); end
    if (out_valid[u] !== 1'b0) begin errors++; $display("[TB] FAIL abort_out_valid got %b want 0", out_valid[u]); end
    if (rk_idx[u] !== 4'd0) begin errors++; $display("[TB] FAIL abort_rk_idx got %0d want 0", rk_idx[u]); end
    if (out_data[u] !== 128'h0) begin errors++; $display("[TB] FAIL abort_out_data got %h want 0", out_data[u]); end
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (out_valid[u] !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("[TB] FAIL abort_no_output got out_valid=1 want 0"); end
    pt = rand128();
    run_block(u, pt, lat);
    checks += 2;
    if (lat != 12) begin errors++; $display("[TB] FAIL abort_fresh_latency got %0d want 12", lat); end
    if (out_data[u] !== aes_model(u, pt)) begin errors++; $display("[TB] FAIL abort_fresh_data got %h want %h", out_data[u], aes_model(u, pt)); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back(input int u);
    int           accept_cyc [$];
    logic [0:127] exp_q [$];
    logic [0:127] exp;
    int cyc, outs, nr;
    nr = nk_tab[u] + 6;
    cyc = 0;
    outs = 0;
    out_ready[u] = 1'b1;
    while (outs < 3 && cyc < 200) begin
      in_data[u]  = rand128();
      in_valid[u] = 1'b1;
      if (in_ready[u]) begin
        exp_q.push_back(aes_model(u, in_data[u]));
        accept_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
      if (out_valid[u]) begin
        checks++;
        outs++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL b2b_spurious u=%0d got %h want no output", u, out_data[u]);
        end else begin
          exp = exp_q.pop_front();
          if (out_data[u] !== exp) begin errors++; $display("[TB] FAIL b2b_data u=%0d got %h want %h", u, out_data[u], exp); end
        end
      end
    end
    in_valid[u] = 1'b0;
    checks++;
    if (outs < 3) begin errors++; $display("[TB] FAIL b2b_timeout u=%0d got %0d outputs want 3", u, outs); end
    for (int i = 1; i < accept_cyc.size(); i++) begin
      checks++;
      if (accept_cyc[i] - accept_cyc[i-1] != nr + 2) begin
        errors++; $display("[TB] FAIL b2b_period u=%0d got %0d want %0d", u, accept_cyc[i] - accept_cyc[i-1], nr + 2);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [0:127] pt;
    int lat;
    for (int u = 0; u < 3; u++) begin
      load_key(u, {rand128(), rand128()});
      repeat (3) begin
        pt = rand128();
        out_ready[u] = 1'b0;
        run_block(u, pt, lat);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        checks += 2;
        if (lat != nk_tab[u] + 6) begin errors++; $display("[TB] FAIL rand_latency u=%0d got %0d want %0d", u, lat, nk_tab[u] + 6); end
        if (out_valid[u] !== 1'b1 || out_data[u] !== aes_model(u, pt)) begin
          errors++; $display("[TB] FAIL rand_data u=%0d got %h (valid %b) want %h", u, out_data[u], out_valid[u], aes_model(u, pt));
        end
        out_ready[u] = 1'b1;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      in_valid[u] = 1'b0; in_data[u] = '0; out_ready[u] = 1'b0;
      for (int r = 0; r < 16; r++) rk_store[u][r] = '0;
    end
    build_sbox();
    test_reset();
    test_known_vectors();
    test_rk_trace();
    test_stall(0);
    test_stall(2);
    test_reset_midflight();
    for (int u = 0; u < 3; u++) test_back_to_back(u);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_iter_core.md
AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 The block SHALL have the parameter: Nk, default 4, key length in 32-bit words; legal values 4, 6, 8.
REQ-002 The block SHALL derive the localparam Nr = Nk + 6 (10/12/14 rounds); any other Nk SHALL fail elaboration.
REQ-003 The block SHALL have the port: clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have the port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have the port: in_valid  input  1  plaintext offered.
REQ-006 The block SHALL have the port: in_ready  output  1  core can accept plaintext.
REQ-007 The block SHALL have the port: in_data  input  [0:127]  plaintext; byte i = bits 8i..8i+7, column-major per FIPS-197.
REQ-008 The block SHALL have the port: rk_idx  output  [3:0]  index of the round key required this cycle.
REQ-009 The block SHALL have the port: rk_in  input  [0:127]  round key rk_idx, driven combinationally by the external key schedule store in the same cycle.
REQ-010 The block SHALL have the port: out_valid  output  1  ciphertext available.
REQ-011 The block SHALL have the port: out_ready  input  1  consumer takes ciphertext.
REQ-012 The block SHALL have the port: out_data  output  [0:127]  ciphertext, same byte order as in_data.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 The round counter rnd SHALL be 4 bits wide and the state register st SHALL be 128 bits wide.
REQ-015 The block SHALL drive in_ready = 1 only in IDLE.
REQ-016 The block SHALL drive out_valid = 1 only in DONE.
REQ-017 The block SHALL drive out_data = st in every state; out_data is don't-care while out_valid = 0.
REQ-018 The block SHALL drive rk_idx = 0 in IDLE, rk_idx = rnd in BUSY, and rk_idx = Nr in DONE.
REQ-019 In IDLE, when in_valid = 1, the block SHALL load st <= in_data XOR rk_in (AddRoundKey with key 0), set rnd <= 1, and move to BUSY.
REQ-020 In BUSY with rnd < Nr, the block SHALL load st <= AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), rk_in) and increment rnd.
REQ-021 In BUSY with rnd = Nr, the block SHALL perform the final round, st <= AddRoundKey(ShiftRows(SubBytes(st)), rk_in) with no MixColumns, and move to DONE.
REQ-022 In DONE, the block SHALL hold st and out_valid until out_ready = 1, then move to IDLE on that edge.
REQ-023 Latency: with acceptance at edge k, out_valid SHALL be high after edge k+Nr (10/12/14 cycles), and there SHALL be no earlier output.
REQ-024 Throughput: one block SHALL be processed per Nr+2 cycles when out_ready is held at 1, with one IDLE bubble between blocks and no overlap.
REQ-025 The block SHALL ignore in_valid outside IDLE; in_data and in_valid need not be held after acceptance.
REQ-026 The block SHALL ignore out_ready outside DONE.
REQ-027 The block SHALL allow rk_in to change freely between cycles, sampling it only on edges in IDLE-accept and BUSY.
REQ-028 The block SHALL implement SubBytes with the FIPS-197 S-box and MixColumns in GF(2^8) with polynomial 0x11B; all arithmetic SHALL be bytewise XOR, with no carries.
REQ-029 The block SHALL ensure rnd never exceeds Nr and never wraps; the DONE transition SHALL occur exactly at rnd = Nr.

Reset
REQ-030 When rst_n = 0 at a rising edge, the block SHALL set FSM <= IDLE, rnd <= 0 and st <= 0, regardless of state.
REQ-031 The block SHALL abort any in-flight block on reset, mid-BUSY or in DONE, with no output produced.
REQ-032 The reset values SHALL be in_ready = 1, out_valid = 0, rk_idx = 0 and out_data = 0 from the first edge with rst_n = 0.
REQ-033 The block SHALL treat in_valid asserted in the same cycle as rst_n = 0 as not accepted.

Verification
REQ-034 Scenario: Nk=4, pt 00112233445566778899aabbccddeeff, key 000102…0f schedule -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 cycles after accept.
REQ-035 Scenario: Nk=6, same pt, key 000102…17 -> dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles; Nk=8, key 000102…1f -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
REQ-036 Scenario: out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready = 0, and rk_idx = Nr throughout.
REQ-037 Scenario: rst_n pulsed low at rnd = 5 -> next cycle in_ready = 1, out_valid = 0, and no ciphertext ever appears; a fresh vector then passes.
REQ-038 Scenario: in_valid held high continuously with out_ready = 1 -> blocks accepted every Nr+2 cycles and each ciphertext matches the model.
REQ-039 Scenario: rk_idx trace per block -> 0, 1, 2, …, Nr in consecutive cycles, matching the schedule reads.
